dct4x4_core: RTL and testbench
==============================

DCT4X4_CORE -- requirements
Module: dct4x4_core

Interface
REQ-001 Parameter: COEF_W, default 16, width of each output coefficient; legal range 14..16.
REQ-002 clk  input  1  single clock; all logic on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 residual_flat  input  32  one residual row; [8i+7:8i] = signed x_i, i=0 is leftmost column.
REQ-005 residual_ready  input  1  residual_flat valid this cycle.
REQ-006 mode  input  2  intra mode of the block; sampled with row 0.
REQ-007 DCT_clear  input  1  synchronous abort of the current block.
REQ-008 in_ready  output  1  block accepts a row this cycle.
REQ-009 coef_flat  output  4*COEF_W  one coefficient row; [COEF_W*(j+1)-1:COEF_W*j] = signed Y_kj.
REQ-010 coef_valid  output  1  coef_flat valid.
REQ-011 coef_ready  input  1  downstream accepts coef_flat.
REQ-012 coef_last  output  1  coefficient row 3 of the block.
REQ-013 coef_mode  output  2  mode latched for the block being output.
REQ-014 ovf_err  output  1  sticky; a row was dropped.

Function
REQ-015 Transform: Y = Cf*X*Cf^T, Cf rows {1,1,1,1}, {2,1,-1,-2}, {1,-1,-1,1}, {1,-2,2,-1}; exact integer arithmetic; no scaling or rounding.
REQ-016 Widths: row stage 11-bit signed; column stage 14-bit signed; output sign-extended to COEF_W.
REQ-017 States: IDLE, LOAD, OUT.
- IDLE -> LOAD on the first accepted row.
- LOAD -> OUT on acceptance of row 3.
- OUT -> IDLE on the handshake of coefficient row 3.
REQ-018 A row is accepted when residual_ready=1 and in_ready=1; in_ready=1 in IDLE and LOAD, 0 in OUT.
REQ-019 The row transform is applied to each accepted row, and the result is stored in a 4x11-bit row buffer indexed by a 2-bit row counter.
REQ-020 mode is latched into coef_mode when row 0 is accepted.
REQ-021 Latency: row 3 accepted at edge N -> coef_valid=1 with coefficient row 0 after edge N+1.
REQ-022 Output rows are produced in order k=0..3; coef_last=1 only with k=3.
REQ-023 Output handshake occurs when coef_valid=1 and coef_ready=1; the next row is presented on the following edge.
REQ-024 While coef_valid=1 and coef_ready=0, coef_flat, coef_last and coef_mode hold stable.
REQ-025 residual_ready=1 while in_ready=0: the row is dropped, ovf_err is set, and the state is unchanged.
REQ-026 After the row-3 handshake, in_ready=1 on the next cycle and coef_valid=0 until the next block completes.
REQ-027 DCT_clear=1 at an edge forces IDLE, row counter 0 and coef_valid=0.
- Priority over residual_ready and coef_ready in the same cycle.
- ovf_err is not cleared.

Reset
REQ-028 rst_n=0 forces:
- state IDLE, row counter 0;
- coef_valid=0, coef_last=0, coef_flat=0, coef_mode=0, ovf_err=0;
- in_ready=1 after release.
REQ-029 Reset mid-block discards all buffered rows.
- The first row after release is row 0 of a new block.

Configuration
REQ-030 Macro DCT4X4_STATS_EN.
- Defined: adds output blk_count (16 bits).
- blk_count increments on each row-3 output handshake, wraps 0xFFFF->0, resets to 0, and is unaffected by DCT_clear.
- Undefined: port and counter absent; all other behaviour identical.

Structure
REQ-031 Shared package dct4x4_pkg holds:
- the state encoding;
- row and column stage width constants (11, 14);
- the Cf coefficient constants.
REQ-032 Sub-module dct4_1d: combinational 4-point Cf butterfly, parameterised input and output width.
- One instance is used for the row stage and one for the column stage.

Verification
REQ-033 All-zero block, coef_ready=1 -> four rows of 0; coef_last only on row 3.
REQ-034 All residuals = 1, mode=2 -> row0 = {16,0,0,0}, rows 1-3 all 0, coef_mode=2.
REQ-035 All residuals = 127 -> Y00 = 2032, others 0; all residuals = -128 -> Y00 = -2048, others 0.
REQ-036 coef_ready held low 3 cycles on row 1 -> coef_flat and coef_valid stable, in_ready=0, then rows 2-3 follow unchanged.
REQ-037 DCT_clear after 2 accepted rows -> coef_valid stays 0; the next 4 rows form a fresh block with correct coefficients.
REQ-038 residual_ready pulsed during OUT -> ovf_err=1, output rows unchanged; ovf_err cleared only by rst_n.

Source files
------------

// File: rtl/dct4x4_pkg.sv
// dct4x4_pkg
// Shared definitions for the 4x4 integer forward transform core:
//   - state_t : controller state encoding
//   - RES_W / ROW_W / COL_W : residual, row-stage and column-stage widths
//   - CF : forward transform matrix Cf (row k, column j)
package dct4x4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam int RES_W = 8;
  localparam int ROW_W = 11;
  localparam int COL_W = 14;

  localparam int CF [4][4] = '{
    '{1,  1,  1,  1},
    '{2,  1, -1, -2},
    '{1, -1, -1,  1},
    '{1, -2,  2, -1}
  };

endpackage

// File: rtl/dct4_1d.sv
// dct4_1d
// Combinational 4-point forward transform y = Cf * x.
// Each of the four points may be a vector of LANES independent lanes, so the
// same block serves the row stage (LANES=1, four scalars of one row) and the
// column stage (LANES=4, four buffered rows combined lane by lane).
// Ports:
//   x_flat : input  [4*LANES*IN_W-1:0]  point e, lane l at bits (e*LANES+l)*IN_W
//   y_flat : output [4*LANES*OUT_W-1:0] point k, lane l at bits (k*LANES+l)*OUT_W
module dct4_1d
  import dct4x4_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 11,
  parameter int LANES = 1
) (
  input  logic [4*LANES*IN_W-1:0]  x_flat,
  output logic [4*LANES*OUT_W-1:0] y_flat
);

  always_comb begin
    int acc;
    y_flat = '0;
    for (int k = 0; k < 4; k++) begin
      for (int l = 0; l < LANES; l++) begin
        acc = 0;
        for (int j = 0; j < 4; j++) begin
          acc += CF[k][j] * int'($signed(x_flat[(j*LANES+l)*IN_W +: IN_W]));
        end
        // OUT_W is sized so the exact result always fits; no saturation needed
        y_flat[(k*LANES+l)*OUT_W +: OUT_W] = OUT_W'(acc);
      end
    end
  end

endmodule

// File: rtl/dct4x4_core.sv
// dct4x4_core
// 4x4 forward integer transform Y = Cf * X * Cf^T on 8-bit signed residuals.
// Rows enter one per accepted cycle; each is row-transformed immediately and
// buffered. Once row 3 is in, the column stage combines the four buffered rows
// and coefficient rows k=0..3 are streamed out under valid/ready.
//
// Optional feature macro: DCT4X4_STATS_EN (adds blk_count output).
//
// Ports:
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   residual_flat  : one residual row, [8i+7:8i] = signed x_i
//   residual_ready : residual_flat valid this cycle
//   mode           : intra mode, sampled with row 0
//   DCT_clear      : synchronous abort of the current block
//   in_ready       : a row is accepted this cycle
//   coef_flat      : one coefficient row, lane j = signed Y_kj (COEF_W bits)
//   coef_valid     : coef_flat valid
//   coef_ready     : downstream accepts coef_flat
//   coef_last      : marks coefficient row 3
//   coef_mode      : mode latched for the block being output
//   ovf_err        : sticky, a row arrived while not accepting
//   blk_count      : (DCT4X4_STATS_EN only) completed blocks, wrapping
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for row 0 of a new block
// ST_LOAD | rows 1..3 being collected
// ST_OUT  | coefficient rows presented; first cycle loads row 0
module dct4x4_core
  import dct4x4_pkg::*;
#(
  parameter int COEF_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         residual_flat,
  input  logic                residual_ready,
  input  logic [1:0]          mode,
  input  logic                DCT_clear,
  output logic                in_ready,
  output logic [4*COEF_W-1:0] coef_flat,
  output logic                coef_valid,
  input  logic                coef_ready,
  output logic                coef_last,
  output logic [1:0]          coef_mode,
  output logic                ovf_err
`ifdef DCT4X4_STATS_EN
  ,
  output logic [15:0]         blk_count
`endif
);

  state_t                      state;
  logic [1:0]                  row_cnt;
  logic [1:0]                  out_k;
  logic [3:0][4*ROW_W-1:0]     row_buf;
  logic [4*ROW_W-1:0]          row_z;
  logic [16*COL_W-1:0]         y_all;
  logic [4*COL_W-1:0]          y_row;
  logic [4*COEF_W-1:0]         next_row;
  logic [1:0]                  sel_k;

  dct4_1d #(
    .IN_W  (RES_W),
    .OUT_W (ROW_W),
    .LANES (1)
  ) u_row_stage (
    .x_flat (residual_flat),
    .y_flat (row_z)
  );

  // row_buf packs row 0 in the low bits, which is exactly the point order
  // the column stage expects
  dct4_1d #(
    .IN_W  (ROW_W),
    .OUT_W (COL_W),
    .LANES (4)
  ) u_col_stage (
    .x_flat (row_buf),
    .y_flat (y_all)
  );

  assign in_ready = (state != ST_OUT);

  // The first OUT cycle (coef_valid still 0) loads row 0; afterwards each
  // handshake loads the following row.
  always_comb begin
    sel_k    = coef_valid ? (out_k + 2'd1) : 2'd0;
    y_row    = y_all[4*COL_W*sel_k +: 4*COL_W];
    next_row = '0;
    for (int j = 0; j < 4; j++) begin
      next_row[COEF_W*j +: COEF_W] = COEF_W'($signed(y_row[COL_W*j +: COL_W]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      row_cnt    <= 2'd0;
      out_k      <= 2'd0;
      row_buf    <= '0;
      coef_flat  <= '0;
      coef_valid <= 1'b0;
      coef_last  <= 1'b0;
      coef_mode  <= 2'd0;
      ovf_err    <= 1'b0;
    end else if (DCT_clear) begin
      state      <= ST_IDLE;
      row_cnt    <= 2'd0;
      out_k      <= 2'd0;
      coef_valid <= 1'b0;
      coef_last  <= 1'b0;
    end else begin
      if (residual_ready && !in_ready) begin
        ovf_err <= 1'b1;
      end
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (residual_ready) begin
            row_buf[row_cnt] <= row_z;
            row_cnt          <= row_cnt + 2'd1;
            if (row_cnt == 2'd0) begin
              coef_mode <= mode;
            end
            state <= (row_cnt == 2'd3) ? ST_OUT : ST_LOAD;
          end
        end
        ST_OUT: begin
          if (!coef_valid) begin
            coef_flat  <= next_row;
            coef_valid <= 1'b1;
            coef_last  <= 1'b0;
            out_k      <= 2'd0;
          end else if (coef_ready) begin
            if (out_k == 2'd3) begin
              coef_valid <= 1'b0;
              coef_last  <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              coef_flat <= next_row;
              out_k     <= out_k + 2'd1;
              coef_last <= (out_k == 2'd2);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DCT4X4_STATS_EN
  // DCT_clear wins over coef_ready, so a handshake never coincides with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_count <= 16'd0;
    end else if (!DCT_clear && coef_valid && coef_ready && coef_last) begin
      blk_count <= blk_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dct4x4_core.sv
module tb_dct4x4_core;

  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [31:0]     residual_flat = '0;
  logic            residual_ready = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic            DCT_clear = 1'b0;
  logic            in_ready;
  logic [4*CW-1:0] coef_flat;
  logic            coef_valid;
  logic            coef_ready = 1'b1;
  logic            coef_last;
  logic [1:0]      coef_mode;
  logic            ovf_err;
`ifdef DCT4X4_STATS_EN
  logic [15:0]     blk_count;
`endif

  dct4x4_core #(.COEF_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .residual_flat  (residual_flat),
    .residual_ready (residual_ready),
    .mode           (mode),
    .DCT_clear      (DCT_clear),
    .in_ready       (in_ready),
    .coef_flat      (coef_flat),
    .coef_valid     (coef_valid),
    .coef_ready     (coef_ready),
    .coef_last      (coef_last),
    .coef_mode      (coef_mode),
    .ovf_err        (ovf_err)
`ifdef DCT4X4_STATS_EN
    ,
    .blk_count      (blk_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4*CW-1:0] flat;
    logic            last;
    logic [1:0]      md;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   blk_done = 0;
  bit   ready_rand = 1'b0;

  int ref_cf [4][4] = '{
    '{1,  1,  1,  1},
    '{2,  1, -1, -2},
    '{1, -1, -1,  1},
    '{1, -2,  2, -1}
  };

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
  endtask

  // Reference: plain matrix product Cf * X * Cf^T
  task automatic push_expected(input int x[4][4], input logic [1:0] md);
    exp_t e;
    int   y;
    for (int k = 0; k < 4; k++) begin
      e.flat = '0;
      for (int j = 0; j < 4; j++) begin
        y = 0;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            y += ref_cf[k][r] * x[r][c] * ref_cf[j][c];
        e.flat[CW*j +: CW] = y[CW-1:0];
      end
      e.last = (k == 3);
      e.md   = md;
      sb.push_back(e);
    end
  endtask

  task automatic rand_block(output int x[4][4]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        x[r][c] = int'($urandom_range(255)) - 128;
  endtask

  task automatic fill_block(output int x[4][4], input int v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        x[r][c] = v;
  endtask

  task automatic send_row(input logic [31:0] data, input logic [1:0] md);
    int budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) timeout_fail("in_ready_wait");
    residual_flat  = data;
    mode           = md;
    residual_ready = 1'b1;
    @(posedge clk);
    #1 residual_ready = 1'b0;
  endtask

  task automatic send_block(input int x[4][4], input logic [1:0] md, input bit chk_lat);
    logic [31:0] d;
    int          v;
    push_expected(x, md);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        v = x[r][c];
        d[8*c +: 8] = v[7:0];
      end
      // mode is only sampled with row 0; other rows carry noise
      send_row(d, (r == 0) ? md : 2'($urandom_range(3)));
    end
    if (chk_lat) begin
      @(negedge clk);
      chk("latency_pre", {63'd0, coef_valid}, 64'd0);
      @(negedge clk);
      chk("latency", {63'd0, coef_valid}, 64'd1);
    end
  endtask

  task automatic send_rand_rows(input int n);
    for (int i = 0; i < n; i++) send_row($urandom, 2'($urandom_range(3)));
  endtask

  task automatic wait_valid();
    int budget = 0;
    @(negedge clk);
    while (!coef_valid && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!coef_valid) timeout_fail("wait_valid");
  endtask

  task automatic wait_drain();
    int budget = 0;
    @(negedge clk);
    while ((sb.size() != 0 || coef_valid) && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() != 0 || coef_valid) timeout_fail("drain");
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1 DCT_clear = 1'b1;
    @(posedge clk);
    #1 DCT_clear = 1'b0;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (ready_rand) coef_ready = ($urandom_range(3) != 0);
  end

  // Monitor: pops the scoreboard on every output handshake and checks hold
  initial begin
    exp_t            e;
    bit              hold_pending = 1'b0;
    logic [4*CW-1:0] hold_flat = '0;
    logic            hold_last = 1'b0;
    logic [1:0]      hold_md = 2'd0;
    forever begin
      @(negedge clk);
      if (!rst_n || DCT_clear) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          chk("hold_valid", {63'd0, coef_valid}, 64'd1);
          chk("hold_flat", coef_flat, hold_flat);
          chk("hold_last", {63'd0, coef_last}, {63'd0, hold_last});
          chk("hold_mode", {62'd0, coef_mode}, {62'd0, hold_md});
        end
        if (coef_valid) chk("in_ready_in_out", {63'd0, in_ready}, 64'd0);
        if (coef_valid && coef_ready) begin
          if (sb.size() == 0) begin
            timeout_fail("unexpected_row");
          end else begin
            e = sb.pop_front();
            chk("coef_flat", coef_flat, e.flat);
            chk("coef_last", {63'd0, coef_last}, {63'd0, e.last});
            chk("coef_mode", {62'd0, coef_mode}, {62'd0, e.md});
            if (e.last) blk_done++;
          end
        end
        hold_pending = coef_valid && !coef_ready;
        hold_flat    = coef_flat;
        hold_last    = coef_last;
        hold_md      = coef_mode;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int blk[4][4];

    repeat (3) @(negedge clk);
    chk("rst_valid", {63'd0, coef_valid}, 64'd0);
    chk("rst_flat", coef_flat, 64'd0);
    chk("rst_last", {63'd0, coef_last}, 64'd0);
    chk("rst_mode", {62'd0, coef_mode}, 64'd0);
    chk("rst_ovf", {63'd0, ovf_err}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    fill_block(blk, 0);
    send_block(blk, 2'd1, 1'b1);
    wait_drain();
    fill_block(blk, 1);
    send_block(blk, 2'd2, 1'b1);
    wait_drain();
    fill_block(blk, 127);
    send_block(blk, 2'd3, 1'b1);
    wait_drain();
    fill_block(blk, -128);
    send_block(blk, 2'd0, 1'b1);
    wait_drain();

    ready_rand = 1'b1;
    for (int b = 0; b < 24; b++) begin
      rand_block(blk);
      send_block(blk, 2'($urandom_range(3)), 1'b1);
    end
    wait_drain();
    ready_rand = 1'b0;
    chk("ovf_quiet", {63'd0, ovf_err}, 64'd0);

    // Backpressure: hold row 1 for three cycles
    @(posedge clk);
    #1 coef_ready = 1'b0;
    rand_block(blk);
    send_block(blk, 2'd1, 1'b0);
    wait_valid();
    @(posedge clk);
    #1 coef_ready = 1'b1;
    @(posedge clk);
    #1 coef_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 coef_ready = 1'b1;
    wait_drain();

    // Abort after two rows, then a fresh block
    send_rand_rows(2);
    #1 DCT_clear = 1'b1;
    @(posedge clk);
    #1 DCT_clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("clear_no_valid", {63'd0, coef_valid}, 64'd0);
    end
    chk("clear_in_ready", {63'd0, in_ready}, 64'd1);
    rand_block(blk);
    send_block(blk, 2'd2, 1'b1);
    wait_drain();

    // Abort while presenting output
    @(posedge clk);
    #1 coef_ready = 1'b0;
    rand_block(blk);
    send_block(blk, 2'd3, 1'b0);
    wait_valid();
    pulse_clear();
    sb.delete();
    @(negedge clk);
    chk("clear_out_valid", {63'd0, coef_valid}, 64'd0);
    chk("clear_out_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 coef_ready = 1'b1;
    rand_block(blk);
    send_block(blk, 2'd1, 1'b1);
    wait_drain();

    // Row pulsed during output: dropped, sticky error, output unaffected
    @(posedge clk);
    #1 coef_ready = 1'b0;
    rand_block(blk);
    send_block(blk, 2'd2, 1'b0);
    wait_valid();
    @(posedge clk);
    #1;
    residual_flat  = $urandom;
    residual_ready = 1'b1;
    @(posedge clk);
    #1 residual_ready = 1'b0;
    @(negedge clk);
    chk("ovf_set", {63'd0, ovf_err}, 64'd1);
    @(posedge clk);
    #1 coef_ready = 1'b1;
    wait_drain();
    rand_block(blk);
    send_block(blk, 2'd0, 1'b1);
    wait_drain();
    pulse_clear();
    @(negedge clk);
    chk("ovf_sticky", {63'd0, ovf_err}, 64'd1);

`ifdef DCT4X4_STATS_EN
    chk("blk_count", {48'd0, blk_count}, 64'(blk_done));
`endif

    // Reset mid-block discards buffered rows
    send_rand_rows(2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_ovf", {63'd0, ovf_err}, 64'd0);
    chk("rst2_valid", {63'd0, coef_valid}, 64'd0);
    chk("rst2_flat", coef_flat, 64'd0);
    rst_n = 1'b1;
    blk_done = 0;
    rand_block(blk);
    send_block(blk, 2'd3, 1'b1);
    wait_drain();
`ifdef DCT4X4_STATS_EN
    chk("blk_count_after_rst", {48'd0, blk_count}, 64'(blk_done));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
